// File: rtl/sub_seq_ctrl_if.sv
// Request/response bundle for sub_seq_ctrl: operand request channel and
// difference/flag response channel, both valid/ready.
interface sub_seq_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_bin;

  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_diff;
  logic         resp_borrow;
  logic         resp_zero;
  logic         resp_ovf;

  // Issue side: presents operands, consumes results.
  modport master (
    output req_valid, req_a, req_b, req_bin, resp_ready,
    input  req_ready, resp_valid, resp_diff, resp_borrow, resp_zero, resp_ovf
  );

  // Controller side.
  modport slave (
    input  req_valid, req_a, req_b, req_bin, resp_ready,
    output req_ready, resp_valid, resp_diff, resp_borrow, resp_zero, resp_ovf
  );
endinterface

// File: rtl/sub_seq_ctrl.sv
// Multi-byte subtract sequencer: walks the operands LSB byte first through
// one shared combinational 8-bit ripple-borrow slice, one byte per clock,
// and returns difference, borrow, zero and signed-overflow flags.
module sub_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  sub_seq_ctrl_if.slave bus,
  output logic [7:0]  sl_a,
  output logic [7:0]  sl_b,
  output logic        sl_cin,
  input  logic [7:0]  sl_sub,
  input  logic        sl_out
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          brw;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  diff_reg;

  // Sequencer: latch operands, step one byte per cycle, hold result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      brw      <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      diff_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_reg <= bus.req_a;
            b_reg <= bus.req_b;
            brw   <= bus.req_bin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          brw <= sl_out;
          for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) diff_reg[8*i +: 8] <= sl_sub;
          end
          // idx parks on the top byte rather than wrapping.
          if (idx == LAST) state <= DONE;
          else             idx   <= idx + 1'b1;
        end
        DONE: begin
          if (bus.resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slice operand mux: current byte in RUN, quiet zeros otherwise.
  always_comb begin
    sl_a   = '0;
    sl_b   = '0;
    sl_cin = 1'b0;
    if (state == RUN) begin
      sl_cin = brw;
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (idx == IW'(i)) begin
          sl_a = a_reg[8*i +: 8];
          sl_b = b_reg[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.resp_valid  = (state == DONE);
  assign bus.resp_diff   = diff_reg;
  assign bus.resp_borrow = brw;
  assign bus.resp_zero   = ~|diff_reg;
  assign bus.resp_ovf    = (a_reg[W-1] ^ b_reg[W-1]) & (diff_reg[W-1] ^ a_reg[W-1]);
endmodule

// File: tb/tb_sub_seq_ctrl.sv
// Bench for sub_seq_ctrl: three instances (4, 3 and 1 bytes wide) each
// with a behavioural slice and a transaction-level reference model.
module tb_sub_seq_ctrl;
  typedef struct packed {
    logic [31:0] d;
    logic        b;
    logic        z;
    logic        v;
  } res_t;

  logic clk;
  logic rst;

  logic [2:0]       i_valid;
  logic [2:0][31:0] i_a;
  logic [2:0][31:0] i_b;
  logic [2:0]       i_bin;
  logic [2:0]       i_rready;

  logic [2:0]       o_rdy;
  logic [2:0]       o_val;
  logic [2:0][31:0] o_diff;
  logic [2:0]       o_brw;
  logic [2:0]       o_zero;
  logic [2:0]       o_ovf;
  logic [2:0][7:0]  o_sla;
  logic [2:0]       o_cin;

  int errors = 0;
  int checks = 0;
  int acc [3] = '{0, 0, 0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int g, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d got=%h want=%h t=%0t", name, g, got, want, $time);
    end
  endtask

  // Reference subtraction of w-bit operands by plain integer arithmetic.
  function automatic res_t ref_sub(input logic [31:0] a, input logic [31:0] b,
                                   input logic bin, input int w);
    longint unsigned la = 64'(a);
    longint unsigned lb = 64'(b);
    longint unsigned m  = (64'd1 << w) - 64'd1;
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint sa, sb, sr;
    res_t r;
    r.d = 32'((la - lb - 64'(bin)) & m);
    r.b = (la < lb + 64'(bin));
    sa  = (la > $unsigned(hi)) ? $signed(la) - 2 * (hi + 1) : $signed(la);
    sb  = (lb > $unsigned(hi)) ? $signed(lb) - 2 * (hi + 1) : $signed(lb);
    sr  = sa - sb - longint'(bin);
    r.v = (sr > hi) || (sr < -hi - 1);
    r.z = (r.d == 32'd0);
    return r;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] v, input int i);
    return 8'(v >> (8 * i));
  endfunction

  // Borrow into byte i: does the low i bytes' subtraction underflow?
  function automatic logic exp_cin(input logic [31:0] a, input logic [31:0] b,
                                   input logic bin, input int i);
    longint unsigned m  = (64'd1 << (8 * i)) - 64'd1;
    longint unsigned la = 64'(a) & m;
    longint unsigned lb = 64'(b) & m;
    return (la < lb + 64'(bin));
  endfunction

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int NB = (g == 0) ? 4 : ((g == 1) ? 3 : 1);
    localparam int W  = 8 * NB;

    sub_seq_ctrl_if #(.NBYTES(NB)) bus ();

    logic [7:0] sl_a, sl_b, sl_sub;
    logic       sl_cin, sl_out;

    assign {sl_out, sl_sub} = {1'b0, sl_a} - {1'b0, sl_b} - {8'd0, sl_cin};

    assign bus.req_valid  = i_valid[g];
    assign bus.req_a      = i_a[g][W-1:0];
    assign bus.req_b      = i_b[g][W-1:0];
    assign bus.req_bin    = i_bin[g];
    assign bus.resp_ready = i_rready[g];

    assign o_rdy[g]  = bus.req_ready;
    assign o_val[g]  = bus.resp_valid;
    assign o_diff[g] = 32'(bus.resp_diff);
    assign o_brw[g]  = bus.resp_borrow;
    assign o_zero[g] = bus.resp_zero;
    assign o_ovf[g]  = bus.resp_ovf;
    assign o_sla[g]  = sl_a;
    assign o_cin[g]  = sl_cin;

    sub_seq_ctrl #(.NBYTES(NB)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .sl_a   (sl_a),
      .sl_b   (sl_b),
      .sl_cin (sl_cin),
      .sl_sub (sl_sub),
      .sl_out (sl_out)
    );

    // Model phase: 0 waiting for request, 1 computing, 2 holding result.
    int          ph   = 0;
    int          cnt  = 0;
    logic [31:0] ma   = '0;
    logic [31:0] mb   = '0;
    logic        mbin = 1'b0;
    res_t        pub  = '0;
    logic        init = 1'b0;

    always @(posedge clk) begin
      if (rst) begin
        ph   <= 0;
        cnt  <= 0;
        ma   <= '0;
        mb   <= '0;
        mbin <= 1'b0;
        pub  <= '{d: 32'd0, b: 1'b0, z: 1'b1, v: 1'b0};
        init <= 1'b1;
      end else if (init) begin
        case (ph)
          0: if (i_valid[g]) begin
            ma     <= 32'(i_a[g][W-1:0]);
            mb     <= 32'(i_b[g][W-1:0]);
            mbin   <= i_bin[g];
            cnt    <= NB;
            ph     <= 1;
            acc[g] <= acc[g] + 1;
          end
          1: begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
              ph  <= 2;
              pub <= ref_sub(ma, mb, mbin, W);
            end
          end
          default: if (i_rready[g]) ph <= 0;
        endcase
      end
    end

    always @(negedge clk) begin
      if (init) begin
        check("req_ready", g, 32'(o_rdy[g]), 32'(ph == 0));
        check("resp_valid", g, 32'(o_val[g]), 32'(ph == 2));
        if (ph == 1) begin
          check("sl_a", g, 32'(sl_a), 32'(exp_byte(ma, NB - cnt)));
          check("sl_b", g, 32'(sl_b), 32'(exp_byte(mb, NB - cnt)));
          check("sl_cin", g, 32'(sl_cin), 32'(exp_cin(ma, mb, mbin, NB - cnt)));
        end else begin
          check("sl_a_idle", g, 32'(sl_a), 32'd0);
          check("sl_b_idle", g, 32'(sl_b), 32'd0);
          check("sl_cin_idle", g, 32'(sl_cin), 32'd0);
          check("resp_diff", g, o_diff[g], pub.d);
          check("resp_borrow", g, 32'(o_brw[g]), 32'(pub.b));
          check("resp_zero", g, 32'(o_zero[g]), 32'(pub.z));
          check("resp_ovf", g, 32'(o_ovf[g]), 32'(pub.v));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!o_val[0] && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // One 4-byte operation on instance 0 with literal expectations.
  task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic bin,
                     input logic [31:0] ed, input logic eb, input logic ez,
                     input logic ev);
    int lat;
    i_a[0] = a; i_b[0] = b; i_bin[0] = bin;
    i_valid[0] = 1'b1; i_rready[0] = 1'b0;
    tick();
    i_valid[0] = 1'b0;
    check("lit_busy", 0, 32'(o_rdy[0]), 32'd0);
    wait_valid(lat);
    check("lit_latency", 0, lat, 32'd4);
    check("lit_diff", 0, o_diff[0], ed);
    check("lit_borrow", 0, 32'(o_brw[0]), 32'(eb));
    check("lit_zero", 0, 32'(o_zero[0]), 32'(ez));
    check("lit_ovf", 0, 32'(o_ovf[0]), 32'(ev));
    i_rready[0] = 1'b1;
    tick();
    i_rready[0] = 1'b0;
    check("lit_idle_ready", 0, 32'(o_rdy[0]), 32'd1);
    check("lit_idle_valid", 0, 32'(o_val[0]), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8080_8080;
      3: return 32'h7F7F_7F7F;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_rand(input int g, input int target);
    int cyc = 0;
    while (acc[g] < target && cyc < 20000) begin
      tick();
      cyc++;
      i_rready[g] = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) != 0) begin
        i_valid[g] = 1'b1;
        i_a[g]     = pick();
        i_b[g]     = pick();
        i_bin[g]   = 1'($urandom_range(0, 1));
      end else begin
        i_valid[g] = 1'b0;
      end
    end
    i_valid[g] = 1'b0;
    checks++;
    if (acc[g] < target) begin
      errors++;
      $display("FAIL rand_timeout inst%0d got=%0d want=%0d", g, acc[g], target);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog inst0 got=hang want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst = 1'b1;
    i_valid = '0; i_a = '0; i_b = '0; i_bin = '0; i_rready = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", 0, 32'(o_rdy[0]), 32'd1);
    check("rst_valid", 0, 32'(o_val[0]), 32'd0);
    check("rst_diff", 0, o_diff[0], 32'd0);
    check("rst_zero", 0, 32'(o_zero[0]), 32'd1);

    op4(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    op4(32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    op4(32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    op4(32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
    op4(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b1);

    // Back-pressure: result must hold and new requests must be ignored.
    i_a[0] = 32'h5; i_b[0] = 32'h3; i_bin[0] = 1'b0; i_valid[0] = 1'b1;
    tick();
    wait_valid(lat);
    check("stall_latency", 0, lat, 32'd4);
    for (int k = 0; k < 10; k++) begin
      i_a[0] = $urandom;
      tick();
      check("stall_valid", 0, 32'(o_val[0]), 32'd1);
      check("stall_ready", 0, 32'(o_rdy[0]), 32'd0);
      check("stall_diff", 0, o_diff[0], 32'h2);
    end
    i_a[0] = 32'h100; i_b[0] = 32'h1; i_rready[0] = 1'b1;
    tick();
    i_rready[0] = 1'b0;
    check("release_valid", 0, 32'(o_val[0]), 32'd0);
    check("release_ready", 0, 32'(o_rdy[0]), 32'd1);
    tick();
    i_valid[0] = 1'b0;
    check("reaccept_ready", 0, 32'(o_rdy[0]), 32'd0);
    wait_valid(lat);
    check("reaccept_diff", 0, o_diff[0], 32'h0000_00FF);
    i_rready[0] = 1'b1;
    tick();
    i_rready[0] = 1'b0;

    // Reset in the middle of a run discards the operation.
    i_a[0] = 32'hDEAD_BEEF; i_b[0] = 32'h1; i_valid[0] = 1'b1;
    tick();
    i_valid[0] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_ready", 0, 32'(o_rdy[0]), 32'd1);
    check("mrst_valid", 0, 32'(o_val[0]), 32'd0);
    check("mrst_diff", 0, o_diff[0], 32'd0);
    check("mrst_zero", 0, 32'(o_zero[0]), 32'd1);
    check("mrst_borrow", 0, 32'(o_brw[0]), 32'd0);
    check("mrst_ovf", 0, 32'(o_ovf[0]), 32'd0);
    check("mrst_sl_a", 0, 32'(o_sla[0]), 32'd0);
    check("mrst_sl_cin", 0, 32'(o_cin[0]), 32'd0);
    tick();
    check("mrst_quiet", 0, 32'(o_val[0]), 32'd0);
    op4(32'h0001_0000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);

    // Random traffic on all three widths, checked by the per-instance models.
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    fork
      drive_rand(0, 340);
      drive_rand(1, 330);
      drive_rand(2, 330);
    join
    i_rready = '1;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
